// File: rtl/ysyx_23060072_wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port among NREQ producers.
// The write request is registered and held until the port takes it. x0 and x16-x31 targets are dropped.
module ysyx_23060072_wb_arbiter #(
  parameter int NREQ       = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*5-1:0] req_addr_i,
  input  logic [NREQ*32-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic              wb_ready_i,
  output logic              wb_flag_o,
  output logic [4:0]        wb_addr_o,
  output logic [31:0]       wb_data_o,
  output logic              err_o
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   rr_q, rr_d, gidx;
  logic            flag_q, err_q;
  logic [4:0]      addr_q, g_addr;
  logic [31:0]     data_q, g_data;
  logic            slot_free, found;
  logic [NREQ-1:0] grant;

  // k-th candidate of the scan: rotating from rr_q, or plain index order in fixed mode
  function automatic logic [IW-1:0] scan_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = FIXED_PRIO ? k : (int'(p) + k) % NREQ;
    return IW'(s);
  endfunction

  assign slot_free = !flag_q || wb_ready_i;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    if (!rst && slot_free) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req_valid_i[scan_idx(rr_q, k)]) begin
          found = 1'b1;
          gidx  = scan_idx(rr_q, k);
        end
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign g_addr = req_addr_i[5*gidx +: 5];
  assign g_data = req_data_i[32*gidx +: 32];
  assign rr_d   = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      rr_q   <= '0;
    end else if (found) begin
      rr_q <= rr_d;
      if (g_addr == 5'd0) begin
        flag_q <= 1'b0;
      end else if (g_addr[4]) begin
        flag_q <= 1'b0;
        err_q  <= 1'b1;
      end else begin
        flag_q <= 1'b1;
        addr_q <= g_addr;
        data_q <= g_data;
      end
    end else if (slot_free) begin
      flag_q <= 1'b0;
    end
  end

  assign req_ready_o = grant;
  assign wb_flag_o   = flag_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = data_q;
  assign err_o       = err_q;
endmodule
